// File: rtl/pc_sequencer.sv
// Program-flow controller: owns the program counter, sequences fetch/execute,
// and resolves the next pc from the decoder's branch command via a small return stack.
module pc_sequencer #(
  parameter int unsigned ADDR_W      = 20,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              fetch_req,
  output logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_ack,
  input  logic              br_valid,
  input  logic [2:0]        br_op,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              sign_flag,
  input  logic              zero_flag,
  output logic [ADDR_W-1:0] pc,
  output logic              taken,
  output logic              halted,
  output logic              stack_ovf,
  output logic              stack_unf
);

  localparam int unsigned PTR_W = $clog2(STACK_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_JMPS = 3'b010;
  localparam logic [2:0] OP_JMPZ = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              taken_reg, taken_next;
  logic              ovf_reg, ovf_next;
  logic              unf_reg, unf_next;
  logic              push_en;
  logic              jump;

  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
  logic [ADDR_W-1:0] seq_pc;
  logic [CNT_W-1:0]  cnt_dec;
  logic [PTR_W-1:0]  top_idx;
  logic              stack_full;
  logic              stack_empty;

  assign seq_pc      = pc_reg + ADDR_W'(1);
  assign cnt_dec     = cnt_reg - CNT_W'(1);
  assign top_idx     = cnt_dec[PTR_W-1:0];
  assign stack_full  = (cnt_reg == CNT_W'(STACK_DEPTH));
  assign stack_empty = (cnt_reg == '0);

  // Stack contents are never cleared; only the count decides what is live.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_mem[cnt_reg[PTR_W-1:0]] <= seq_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      pc_reg    <= RESET_PC;
      cnt_reg   <= '0;
      taken_reg <= 1'b0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      cnt_reg   <= cnt_next;
      taken_reg <= taken_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    cnt_next   = cnt_reg;
    taken_next = 1'b0;
    ovf_next   = ovf_reg;
    unf_next   = unf_reg;
    push_en    = 1'b0;
    jump       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (run) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (fetch_ack) state_next = ST_EXEC;
      end
      ST_EXEC: begin
        state_next = run ? ST_FETCH : ST_IDLE;
        pc_next    = seq_pc;
        if (br_valid) begin
          case (br_op)
            OP_JMP: begin
              pc_next = br_target;
              jump    = 1'b1;
            end
            OP_JMPS: begin
              if (sign_flag) begin
                pc_next = br_target;
                jump    = 1'b1;
              end
            end
            OP_JMPZ: begin
              if (zero_flag) begin
                pc_next = br_target;
                jump    = 1'b1;
              end
            end
            OP_CALL: begin
              // A call on a full stack still jumps; the return address is lost.
              pc_next = br_target;
              jump    = 1'b1;
              if (stack_full) begin
                ovf_next = 1'b1;
              end else begin
                push_en  = 1'b1;
                cnt_next = cnt_reg + CNT_W'(1);
              end
            end
            OP_RET: begin
              if (stack_empty) begin
                unf_next = 1'b1;
              end else begin
                pc_next  = stack_mem[top_idx];
                cnt_next = cnt_dec;
                jump     = 1'b1;
              end
            end
            OP_HALT: begin
              pc_next    = pc_reg;
              state_next = ST_HALTED;
            end
            default: ;
          endcase
        end
        taken_next = jump | (pc_next != seq_pc);
      end
      ST_HALTED: begin
        state_next = ST_HALTED;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign fetch_req  = (state_reg == ST_FETCH);
  assign halted     = (state_reg == ST_HALTED);
  assign fetch_addr = pc_reg;
  assign pc         = pc_reg;
  assign taken      = taken_reg;
  assign stack_ovf  = ovf_reg;
  assign stack_unf  = unf_reg;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-flow controller for the CPU core. Owns the 20-bit program counter and sequences each instruction: fetch at `pc`, then resolve the next `pc` from the branch command presented by the decoder. Covers sequential advance, JMP, the sign-conditional jump (JMPS), the zero-conditional jump (JMPZ), CALL/RET through a small return stack, and HALT. It is the single writer of `pc` and replaces ad-hoc per-instruction new-pc muxing.

## Interface
- `ADDR_W`, 20, width of pc and all addresses
- `RESET_PC`, 20'h00000, pc value after reset
- `STACK_DEPTH`, 4, return-stack entries (power of two, ≥2)

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset; one clock, asynchronous, active-low
- `run`  in  1  level; enables leaving IDLE
- `fetch_req`  out  1  fetch request; high in FETCH state
- `fetch_addr`  out  ADDR_W  address to fetch; equals `pc`
- `fetch_ack`  in  1  fetch complete; sampled only while `fetch_req`=1
- `br_valid`  in  1  branch command valid; sampled only in EXEC
- `br_op`  in  3  000 NEXT, 001 JMP, 010 JMPS, 011 JMPZ, 100 CALL, 101 RET, 110 HALT, 111 NEXT
- `br_target`  in  ADDR_W  jump/call destination
- `sign_flag`  in  1  ALU sign flag, sampled in EXEC
- `zero_flag`  in  1  ALU zero flag, sampled in EXEC
- `pc`  out  ADDR_W  current program counter (registered)
- `taken`  out  1  one-cycle pulse: non-sequential pc update occurred
- `halted`  out  1  high in HALTED state
- `stack_ovf`  out  1  sticky: CALL with full stack
- `stack_unf`  out  1  sticky: RET with empty stack

## Operation
- States: IDLE, FETCH, EXEC, HALTED.
- IDLE: `run`=1 → FETCH; else stay.
- FETCH: `fetch_req`=1, `fetch_addr`=`pc`. Hold until `fetch_ack`=1, then → EXEC. `run` dropping during FETCH does not abort the request.
- EXEC, one cycle: compute next pc and write `pc`. Next state is FETCH if `run`=1, else IDLE; HALT goes to HALTED.
- Next-pc rules (`seq` = `pc`+1 mod 2^ADDR_W; 20'hFFFFF wraps to 20'h00000):
  - `br_valid`=0, NEXT, or 111: `seq`.
  - JMP: `br_target`.
  - JMPS: `br_target` if `sign_flag`=1, else `seq`.
  - JMPZ: `br_target` if `zero_flag`=1, else `seq`.
  - CALL: push `seq` and jump to `br_target`. If the stack is full: no push, set `stack_ovf`, jump anyway.
  - RET: pop the top entry into pc. If the stack is empty: set `stack_unf`, pc = `seq`.
  - HALT: pc unchanged; → HALTED.
- `taken`=1 in the cycle after EXEC whenever the new pc ≠ `seq`, or the op was JMP/taken JMPS/taken JMPZ/CALL/successful RET. This includes a jump to `seq` itself.
- HALTED: `fetch_req`=0. Left only by reset.
- Return stack is LIFO with a count register from 0 to STACK_DEPTH. Contents are not cleared by pop.

## Timing
- Reset (async assert, sync-safe release):
  - `pc`=RESET_PC, state=IDLE, stack count=0.
  - `fetch_req`, `taken`, `halted`, `stack_ovf`, `stack_unf` all 0.
- Reset mid-instruction aborts immediately, including an outstanding fetch; no pending state survives.
- `fetch_req` and `halted` decode directly from the state register; `fetch_addr` = `pc` register.
- Minimum 2 cycles per instruction: FETCH with same-cycle ack, then EXEC.
- `pc` updates on the clock edge ending EXEC. The next FETCH presents the new pc in the following cycle.
- Flags, `br_*` and `br_target` need be valid only in the EXEC cycle.
- `stack_ovf`/`stack_unf` set on the edge ending the offending EXEC; cleared only by reset.

## Test plan
- Reset, `run`=1, ack every FETCH, `br_valid`=0 for 3 instructions → fetch_addr 00000, 00001, 00002; `taken` never high.
- At pc=00010: JMPS, `br_target`=ABCDE, `sign_flag`=0 → pc=00011, `taken`=0. Repeat at 00011 with `sign_flag`=1 → pc=ABCDE, `taken` pulses 1 cycle.
- From pc=00100: CALL to 00200, then CALL to 00300, then RET, then RET → pcs 00200, 00300, 00201, 00101.
- Five CALLs with STACK_DEPTH=4 → `stack_ovf`=1 after the 5th and the jump is still taken. Five RETs → four pops, then `stack_unf`=1 and pc=popped+1.
- pc=FFFFF with NEXT → pc=00000. Hold `fetch_ack`=0 for 5 cycles → `fetch_req` stays 1 and pc is stable.
- HALT → `halted`=1, no further `fetch_req` with `run`=1. Assert `rst_n`=0 mid-FETCH → all outputs go to reset values without waiting for a clock edge.
